// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data_sram responder: config-region offsets,
// the read-strobe constant, config register selector and a byte-lane
// merge helper used by both the RAM front end and the config registers.
package data_sram_responder_pkg;

    localparam logic [15:0] CONF_BASE_HI     = 16'hBFAF;
    localparam logic [15:0] CONF_LED_OFF     = 16'h0000;
    localparam logic [15:0] CONF_SWITCH_OFF  = 16'h0004;
    localparam logic [15:0] CONF_TIMER_OFF   = 16'h0008;
    localparam logic [15:0] CONF_SCRATCH_OFF = 16'h000C;
    localparam logic [15:0] CONF_NUM_OFF     = 16'h0010;
    localparam logic [3:0]  WEN_READ         = 4'b0000;

    typedef enum logic [2:0] {
        CONF_SEL_LED,
        CONF_SEL_SWITCH,
        CONF_SEL_TIMER,
        CONF_SEL_SCRATCH,
        CONF_SEL_NUM,
        CONF_SEL_NONE
    } conf_sel_e;

    // Map a word offset inside the config window to the register it names.
    function automatic conf_sel_e decode_conf(input logic [13:0] word_off);
        conf_sel_e sel;
        case ({word_off, 2'b00})
            CONF_LED_OFF:     sel = CONF_SEL_LED;
            CONF_SWITCH_OFF:  sel = CONF_SEL_SWITCH;
            CONF_TIMER_OFF:   sel = CONF_SEL_TIMER;
            CONF_SCRATCH_OFF: sel = CONF_SEL_SCRATCH;
            CONF_NUM_OFF:     sel = CONF_SEL_NUM;
            default:          sel = CONF_SEL_NONE;
        endcase
        return sel;
    endfunction

    // Replace only the byte lanes whose write enable is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  wen);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = wen[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data_sram bus: request (en/wen/addr/wdata) from the CPU side and
// read data returned by the responder one cycle after a read request.
interface data_sram_responder_if;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, output wen, output addr, output wdata, input rdata);
    modport slave  (input en, input wen, input addr, input wdata, output rdata);

endinterface

// File: rtl/data_sram_responder_confreg_regs.sv
// Config register block behind the data_sram responder: LED, switch
// synchroniser, free-running timer, scratch and seven-segment number.
// The timer only exists when CONFREG_TIMER_EN is defined; otherwise its
// offset reads as zero and writes to it are dropped.
module confreg_regs
    import data_sram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [3:0]  wen,
    input  logic [13:0] word_off,
    input  logic [31:0] wdata,
    input  logic [7:0]  switch,
    output logic [31:0] rd_data,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    conf_sel_e   sel;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [31:0] scratch;

    assign sel = decode_conf(word_off);

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    // Byte-masked writes to the plain read/write registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led      <= '0;
            scratch  <= '0;
            num_data <= '0;
        end else if (wr_en) begin
            case (sel)
                CONF_SEL_LED: begin
                    if (wen[0]) led[7:0]  <= wdata[7:0];
                    if (wen[1]) led[15:8] <= wdata[15:8];
                end
                CONF_SEL_SCRATCH: scratch  <= merge_lanes(scratch, wdata, wen);
                CONF_SEL_NUM:     num_data <= merge_lanes(num_data, wdata, wen);
                default: ;
            endcase
        end
    end

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer;

    // Free-running counter; a write overrides the enabled lanes of the
    // incremented value so unmasked lanes keep counting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
        end else if (wr_en && (sel == CONF_SEL_TIMER)) begin
            timer <= merge_lanes(timer + 32'd1, wdata, wen);
        end else begin
            timer <= timer + 32'd1;
        end
    end
`endif

    // Read mux; unmapped offsets and the absent timer read as zero.
    always_comb begin
        rd_data = '0;
        case (sel)
            CONF_SEL_LED:     rd_data = {16'h0000, led};
            CONF_SEL_SWITCH:  rd_data = {24'h000000, sw_sync};
`ifdef CONFREG_TIMER_EN
            CONF_SEL_TIMER:   rd_data = timer;
`endif
            CONF_SEL_SCRATCH: rd_data = scratch;
            CONF_SEL_NUM:     rd_data = num_data;
            default:          rd_data = '0;
        endcase
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data_sram bus: a single-port word RAM with
// one-cycle read latency plus a memory-mapped config register block.
// Optional feature macro: CONFREG_TIMER_EN (enables the TIMER register).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] CONF_BASE = {CONF_BASE_HI, 16'h0000}
) (
    input  logic                  clk,
    input  logic                  resetn,
    data_sram_responder_if.slave  data_sram,
    input  logic [7:0]            switch,
    output logic [15:0]           led,
    output logic [31:0]           num_data
);

    logic              conf_hit;
    logic              rd_req;
    logic              wr_req;
    logic              ram_we;
    logic              conf_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_word;
    logic [31:0]       conf_rdata;
    logic [31:0]       rdata_q;
    logic              unused_addr_bits;
    logic [31:0]       ram [2**ADDR_W];

    assign conf_hit = (data_sram.addr[31:16] == CONF_BASE[31:16]);
    assign rd_req   = data_sram.en && (data_sram.wen == WEN_READ);
    assign wr_req   = data_sram.en && (data_sram.wen != WEN_READ);
    assign ram_idx  = data_sram.addr[ADDR_W+1:2];
    assign ram_word = ram[ram_idx];
    assign ram_we   = wr_req && !conf_hit && resetn;
    assign conf_we  = wr_req && conf_hit;

    assign unused_addr_bits = ^data_sram.addr[1:0];

    confreg_regs u_confreg (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (conf_we),
        .wen      (data_sram.wen),
        .word_off (data_sram.addr[15:2]),
        .wdata    (data_sram.wdata),
        .switch   (switch),
        .rd_data  (conf_rdata),
        .led      (led),
        .num_data (num_data)
    );

    // RAM array is not reset so its contents survive a reset pulse; a write
    // presented while reset is held is dropped.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram.wen[i]) begin
                    ram[ram_idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (rd_req) begin
            rdata_q <= conf_hit ? conf_rdata : ram_word;
        end
    end

    assign data_sram.rdata = rdata_q;

endmodule
